// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-cycle data memory.
// Supports lockable bursts with a starvation limit and returns a registered response one cycle after each grant.
module dmem_arbiter #(
    parameter logic [31:0] DATA_SEG_BEGIN = 32'h1000,
    parameter int unsigned MAX_BURST      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        lock0_i,
    input  logic        lock1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    input  logic [3:0]  wstrb0_i,
    input  logic [3:0]  wstrb1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic        rsp_valid0_o,
    output logic        rsp_valid1_o,
    output logic [31:0] rdata0_o,
    output logic [31:0] rdata1_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    if (MAX_BURST < 1 || MAX_BURST > 255 || DATA_SEG_BEGIN[1:0] != 2'b00) begin : g_param_check
        $error("dmem_arbiter: MAX_BURST must be 1..255 and DATA_SEG_BEGIN word aligned");
    end

    logic        rr_ptr_q, rr_ptr_d;
    logic        owner_q, owner_d;
    logic        owned_q, owned_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic        rsp_valid0_q, rsp_valid0_d;
    logic        rsp_valid1_q, rsp_valid1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic gnt0, gnt1, forced, owner_req, other_req, lock_g;

    // Grant decision: locked owner first (unless it has hit the burst limit), then round-robin.
    always_comb begin : arbitrate
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        forced    = 1'b0;
        owner_req = owner_q ? req1_i : req0_i;
        other_req = owner_q ? req0_i : req1_i;
        if (rst_n) begin
            if (owned_q && owner_req) begin
                if (other_req && burst_cnt_q == BURST_LIMIT) begin
                    forced = 1'b1;
                    gnt0   = owner_q;
                    gnt1   = ~owner_q;
                end else begin
                    gnt0 = ~owner_q;
                    gnt1 = owner_q;
                end
            end else if (req0_i && !req1_i) begin
                gnt0 = 1'b1;
            end else if (req1_i && !req0_i) begin
                gnt1 = 1'b1;
            end else if (req0_i && req1_i) begin
                gnt0 = ~rr_ptr_q;
                gnt1 = rr_ptr_q;
            end
        end
    end

    always_comb begin : mem_mux
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        mem_we_o    = 1'b0;
        if (gnt0) begin
            mem_addr_o  = addr0_i;
            mem_wdata_o = wdata0_i;
            mem_wstrb_o = wstrb0_i;
            mem_we_o    = we0_i;
        end else if (gnt1) begin
            mem_addr_o  = addr1_i;
            mem_wdata_o = wdata1_i;
            mem_wstrb_o = wstrb1_i;
            mem_we_o    = we1_i;
        end
    end

    always_comb begin : next_state
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        owned_d      = owned_q;
        burst_cnt_d  = burst_cnt_q;
        rsp_valid0_d = gnt0;
        rsp_valid1_d = gnt1;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        lock_g       = gnt1 ? lock1_i : lock0_i;

        // An owner that stops requesting gives up its lock.
        if (owned_q && !owner_req) begin
            owned_d     = 1'b0;
            burst_cnt_d = '0;
        end

        if (gnt0 || gnt1) begin
            rr_ptr_d = ~gnt1;
            if (forced || !lock_g) begin
                owned_d     = 1'b0;
                burst_cnt_d = '0;
            end else if (owned_q && owner_q == gnt1) begin
                burst_cnt_d = (burst_cnt_q == 8'hFF) ? 8'hFF : burst_cnt_q + 8'd1;
            end else begin
                owner_d     = gnt1;
                owned_d     = 1'b1;
                burst_cnt_d = 8'd1;
            end
        end

        if (gnt0) rdata0_d = we0_i ? '0 : mem_rdata_i;
        if (gnt1) rdata1_d = we1_i ? '0 : mem_rdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= 1'b0;
            owner_q      <= 1'b0;
            owned_q      <= 1'b0;
            burst_cnt_q  <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            owned_q      <= owned_d;
            burst_cnt_q  <= burst_cnt_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign gnt0_o       = gnt0;
    assign gnt1_o       = gnt1;
    assign rsp_valid0_o = rsp_valid0_q;
    assign rsp_valid1_o = rsp_valid1_q;
    assign rdata0_o     = rdata0_q;
    assign rdata1_o     = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a rule-level model of arbitration and memory.
module tb_dmem_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  lock = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];

    logic        gnt0, gnt1, rv0, rv1, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    int total = 0;
    int bad = 0;

    // Model state (after the last edge) and its pending next value
    int          m_rr, m_owner, m_burst;
    bit          m_owned, m_rv0, m_rv1;
    logic [31:0] m_rd0, m_rd1;
    int          n_rr, n_owner, n_burst;
    bit          n_owned, n_rv0, n_rv1;
    logic [31:0] n_rd0, n_rd1;
    int          exp_g;

    dmem_arbiter #(.DATA_SEG_BEGIN(32'h1000), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req[0]), .req1_i(req[1]),
        .lock0_i(lock[0]), .lock1_i(lock[1]),
        .addr0_i(addr[0]), .addr1_i(addr[1]),
        .wdata0_i(wdata[0]), .wdata1_i(wdata[1]),
        .wstrb0_i(wstrb[0]), .wstrb1_i(wstrb[1]),
        .we0_i(we[0]), .we1_i(we[1]),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .rsp_valid0_o(rv0), .rsp_valid1_o(rv1),
        .rdata0_o(rdata0), .rdata1_o(rdata1),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb), .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    // Single-cycle byte-strobed memory; reset fills a known pattern.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5A5A0000 ^ (i * 32'h00010101);
        end else if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        int          g;
        bit          forced;
        logic [31:0] ea, ed;
        logic [3:0]  es;
        logic        ew;
        g = -1;
        forced = 1'b0;
        if (rst_n) begin
            if (m_owned && req[m_owner]) begin
                if (req[1-m_owner] && m_burst == MB) begin
                    g = 1 - m_owner;
                    forced = 1'b1;
                end else begin
                    g = m_owner;
                end
            end else if (req[0] && req[1]) g = m_rr;
            else if (req[0]) g = 0;
            else if (req[1]) g = 1;
        end
        exp_g = g;
        ea = '0; ed = '0; es = '0; ew = 1'b0;
        if (g >= 0) begin
            ea = addr[g]; ed = wdata[g]; es = wstrb[g]; ew = we[g];
        end
        chk("gnt0", 32'(gnt0), 32'(g == 0));
        chk("gnt1", 32'(gnt1), 32'(g == 1));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(es));
        chk("mem_we", 32'(mem_we), 32'(ew));
        chk("rsp_valid0", 32'(rv0), 32'(rst_n && m_rv0));
        chk("rsp_valid1", 32'(rv1), 32'(rst_n && m_rv1));
        if (!rst_n) begin
            chk("rdata0_rst", rdata0, 32'h0);
            chk("rdata1_rst", rdata1, 32'h0);
        end else begin
            if (m_rv0) chk("rdata0", rdata0, m_rd0);
            if (m_rv1) chk("rdata1", rdata1, m_rd1);
        end

        if (!rst_n) begin
            n_rr = 0; n_owner = 0; n_owned = 1'b0; n_burst = 0;
            n_rv0 = 1'b0; n_rv1 = 1'b0; n_rd0 = '0; n_rd1 = '0;
        end else begin
            n_rr = m_rr; n_owner = m_owner; n_owned = m_owned; n_burst = m_burst;
            n_rd0 = m_rd0; n_rd1 = m_rd1;
            n_rv0 = (g == 0); n_rv1 = (g == 1);
            if (m_owned && !req[m_owner]) begin
                n_owned = 1'b0; n_burst = 0;
            end
            if (g >= 0) begin
                n_rr = 1 - g;
                if (forced || !lock[g]) begin
                    n_owned = 1'b0; n_burst = 0;
                end else if (m_owned && m_owner == g) begin
                    n_burst = (m_burst < 255) ? m_burst + 1 : 255;
                end else begin
                    n_owner = g; n_owned = 1'b1; n_burst = 1;
                end
            end
            if (g == 0) n_rd0 = we[0] ? 32'h0 : mem[addr[0][9:2]];
            if (g == 1) n_rd1 = we[1] ? 32'h0 : mem[addr[1][9:2]];
        end
    endtask

    // One clock cycle: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        m_rr = n_rr; m_owner = n_owner; m_owned = n_owned; m_burst = n_burst;
        m_rv0 = n_rv0; m_rv1 = n_rv1; m_rd0 = n_rd0; m_rd1 = n_rd1;
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic l, input logic w,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req[p] = r; lock[p] = l; we[p] = w; addr[p] = a; wdata[p] = d; wstrb[p] = s;
    endtask

    task automatic idle();
        set_port(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        pl_idx = idx; pl_val = val; pl_en = 1'b1;
        step();
        pl_en = 1'b0;
    endtask

    initial begin
        bit [3:0] pat2;
        bit [5:0] pat3;
        bit       pend [2];
        m_rr = 0; m_owner = 0; m_burst = 0; m_owned = 1'b0;
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
        exp_g = -1;
        idle();

        // Reset state
        do_reset();
        #1;
        chk("reset gnt0", 32'(gnt0), 32'h0);
        chk("reset rsp_valid1", 32'(rv1), 32'h0);
        chk("reset rdata0", rdata0, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);

        // Single read of 0x1004
        preload(8'd1, 32'hDEADBEEF);
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h1004, 32'h0, 4'hF);
        #1;
        chk("read gnt0", 32'(gnt0), 32'h1);
        chk("read gnt1", 32'(gnt1), 32'h0);
        step();
        idle();
        #1;
        chk("read rsp_valid0", 32'(rv0), 32'h1);
        chk("read rdata0", rdata0, 32'hDEADBEEF);
        chk("read rsp_valid1", 32'(rv1), 32'h0);
        step();

        // Contention without lock: 0,1,0,1
        do_reset();
        pat2 = 4'b0101;
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h1010, 32'h0, 4'hF);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h1014, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr gnt0", 32'(gnt0), 32'(pat2[k]));
            if (k > 0) chk("rr rsp_valid0", 32'(rv0), 32'(pat2[k-1]));
            step();
        end
        idle();
        step();

        // Locked burst on port 1, port 0 joins one cycle later
        do_reset();
        pat3 = 6'b101111;
        for (int k = 0; k < 6; k++) begin
            set_port(1, 1'b1, 1'b1, 1'b0, 32'h1020 + 32'(k * 4), 32'h0, 4'hF);
            if (k >= 1) set_port(0, 1'b1, 1'b0, 1'b0, 32'h1040, 32'h0, 4'hF);
            #1;
            chk("burst gnt1", 32'(gnt1), 32'(pat3[k]));
            step();
        end
        idle();
        step();

        // Strobed write then read-back
        do_reset();
        preload(8'd2, 32'h11223344);
        set_port(1, 1'b1, 1'b0, 1'b1, 32'h1008, 32'hAABBCCDD, 4'b0010);
        #1;
        chk("wr gnt1", 32'(gnt1), 32'h1);
        chk("wr mem_wstrb", 32'(mem_wstrb), 32'h2);
        chk("wr mem_we", 32'(mem_we), 32'h1);
        chk("wr mem_addr", mem_addr, 32'h1008);
        step();
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h1008, 32'h0, 4'hF);
        #1;
        chk("wr rsp_valid1", 32'(rv1), 32'h1);
        chk("wr rdata1", rdata1, 32'h0);
        step();
        idle();
        #1;
        chk("rb rdata1", rdata1, 32'h1122CC44);
        step();

        // Idle
        step();
        #1;
        chk("idle mem_we", 32'(mem_we), 32'h0);
        chk("idle mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("idle gnt", 32'({gnt0, gnt1}), 32'h0);
        chk("idle rsp", 32'({rv0, rv1}), 32'h0);
        step();

        // Reset during the third locked grant
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_port(1, 1'b1, 1'b1, 1'b1, 32'h1030, 32'h12345678, 4'hF);
            step();
        end
        #1;
        chk("mid pre rsp_valid1", 32'(rv1), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid gnt1", 32'(gnt1), 32'h0);
        chk("mid rsp_valid1", 32'(rv1), 32'h0);
        chk("mid mem_we", 32'(mem_we), 32'h0);
        chk("mid mem_addr", mem_addr, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h1050, 32'h0, 4'hF);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h1054, 32'h0, 4'hF);
        #1;
        chk("post gnt0", 32'(gnt0), 32'h1);
        chk("post gnt1", 32'(gnt1), 32'h0);
        step();

        // Randomized traffic; a request is held until granted
        do_reset();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] || exp_g == p) begin
                    pend[p] = ($urandom_range(0, 4) != 0);
                    set_port(p, pend[p], ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                             (($urandom_range(0, 3) == 0) ? 32'h0 : 32'h1000) | 32'($urandom_range(0, 255) << 2),
                             $urandom, 4'($urandom_range(0, 15)));
                end
            end
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
